// File: rtl/lfm_pinc_gen_pkg.sv
// lfm_pkg: FSM states, default widths and shadow-config type for the LFM chirp sequencer
package lfm_pkg;
   localparam int PINC_W_DEF = 32;
   localparam int CNT_W_DEF  = 16;
   typedef enum logic [1:0] {IDLE, CHIRP, GAP} state_t;
   typedef struct packed {
      logic [PINC_W_DEF-1:0] f_start;
      logic [PINC_W_DEF-1:0] f_step;
      logic [CNT_W_DEF-1:0]  n_samp;
      logic [CNT_W_DEF-1:0]  n_gap;
      logic [CNT_W_DEF-1:0]  n_chirps;
   } shadow_cfg_t;
endpackage

// File: rtl/lfm_pinc_gen.sv
// lfm_pinc_gen: linear-FM chirp burst sequencer emitting DDS phase increments as an AXI-Stream
module lfm_pinc_gen
   import lfm_pkg::*;
#(
   parameter int PINC_W = PINC_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              sys_clock,
   input  logic              sys_resetn,
   input  logic              start,
   input  logic              stop,
   input  logic [PINC_W-1:0] cfg_f_start,
   input  logic [PINC_W-1:0] cfg_f_step,
   input  logic [CNT_W-1:0]  cfg_n_samp,
   input  logic [CNT_W-1:0]  cfg_n_gap,
   input  logic [CNT_W-1:0]  cfg_n_chirps,
   output logic [PINC_W-1:0] m_axis_pinc_tdata,
   output logic              m_axis_pinc_tvalid,
   input  logic              m_axis_pinc_tready,
   output logic              m_axis_pinc_tlast,
   output logic              m_axis_pinc_tuser,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic [CNT_W-1:0]  chirp_idx
);
   state_t            r_state;
   shadow_cfg_t       r_cfg;
   logic [PINC_W-1:0] r_tdata;
   logic              r_tvalid, r_tlast, r_tuser, r_done, r_cfg_err, r_stop_pend;
   logic [CNT_W-1:0]  r_samp, r_gap, r_chirp_idx;
   logic              w_hs, w_abort, w_fin;
   logic [CNT_W-1:0]  w_samp_nxt, w_idx_nxt;

   assign w_hs       = r_tvalid & m_axis_pinc_tready;
   assign w_abort    = stop | r_stop_pend;
   assign w_samp_nxt = r_samp + CNT_W'(1);
   assign w_idx_nxt  = r_chirp_idx + CNT_W'(1);
   assign w_fin      = (r_cfg.n_chirps != '0) && (w_idx_nxt == r_cfg.n_chirps);

   always_ff @(posedge sys_clock) begin
      if (!sys_resetn) begin
         r_state     <= IDLE;
         r_cfg       <= '0;
         r_tdata     <= '0;
         r_tvalid    <= 1'b0;
         r_tlast     <= 1'b0;
         r_tuser     <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_stop_pend <= 1'b0;
         r_samp      <= '0;
         r_gap       <= '0;
         r_chirp_idx <= '0;
      end else begin
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !stop) begin
                  if (cfg_n_samp == '0) begin
                     r_cfg_err <= 1'b1;
                  end else begin
                     r_cfg       <= '{cfg_f_start, cfg_f_step, cfg_n_samp, cfg_n_gap, cfg_n_chirps};
                     r_chirp_idx <= '0;
                     r_samp      <= '0;
                     r_tdata     <= cfg_f_start;
                     r_tuser     <= 1'b1;
                     r_tlast     <= (cfg_n_samp == CNT_W'(1));
                     r_tvalid    <= 1'b1;
                     r_stop_pend <= 1'b0;
                     r_state     <= CHIRP;
                  end
               end
            end
            CHIRP: begin
               if (stop) r_stop_pend <= 1'b1;
               if (w_hs) begin
                  if (r_tlast) begin
                     // chirp boundary: rewind the ramp so the next beat is already staged
                     r_chirp_idx <= w_idx_nxt;
                     r_tdata     <= r_cfg.f_start;
                     r_samp      <= '0;
                     r_tuser     <= 1'b1;
                     r_tlast     <= (r_cfg.n_samp == CNT_W'(1));
                  end else begin
                     r_tdata <= r_tdata + r_cfg.f_step;
                     r_samp  <= w_samp_nxt;
                     r_tuser <= 1'b0;
                     r_tlast <= (w_samp_nxt == r_cfg.n_samp - CNT_W'(1));
                  end
                  if (r_tlast && w_fin) begin
                     r_state     <= IDLE;
                     r_tvalid    <= 1'b0;
                     r_done      <= 1'b1;
                     r_stop_pend <= 1'b0;
                  end else if (w_abort) begin
                     r_state     <= IDLE;
                     r_tvalid    <= 1'b0;
                     r_stop_pend <= 1'b0;
                  end else if (r_tlast && r_cfg.n_gap != '0) begin
                     r_state  <= GAP;
                     r_tvalid <= 1'b0;
                     r_gap    <= '0;
                  end
               end
            end
            GAP: begin
               if (stop) begin
                  r_state <= IDLE;
               end else if (r_gap == r_cfg.n_gap - CNT_W'(1)) begin
                  r_state  <= CHIRP;
                  r_tvalid <= 1'b1;
               end else begin
                  r_gap <= r_gap + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign m_axis_pinc_tdata  = r_tdata;
   assign m_axis_pinc_tvalid = r_tvalid;
   assign m_axis_pinc_tlast  = r_tlast;
   assign m_axis_pinc_tuser  = r_tuser;
   assign busy               = (r_state != IDLE);
   assign done               = r_done;
   assign cfg_err            = r_cfg_err;
   assign chirp_idx          = r_chirp_idx;
endmodule

// File: tb/tb_lfm_pinc_gen.sv
// tb_lfm_pinc_gen: directed and randomized bursts checked against an arithmetic chirp model
module tb_lfm_pinc_gen;
   logic        sys_clock = 1'b0;
   logic        sys_resetn = 1'b0;
   logic        start = 1'b0, stop = 1'b0;
   logic [31:0] cfg_f_start = '0, cfg_f_step = '0;
   logic [15:0] cfg_n_samp = '0, cfg_n_gap = '0, cfg_n_chirps = '0;
   logic [31:0] tdata;
   logic        tvalid, tlast, tuser, busy, done, cfg_err;
   logic        tready = 1'b0;
   logic [15:0] chirp_idx;
   int          n_cmp = 0, n_err = 0;

   lfm_pinc_gen dut (
      .sys_clock(sys_clock), .sys_resetn(sys_resetn), .start(start), .stop(stop),
      .cfg_f_start(cfg_f_start), .cfg_f_step(cfg_f_step), .cfg_n_samp(cfg_n_samp),
      .cfg_n_gap(cfg_n_gap), .cfg_n_chirps(cfg_n_chirps),
      .m_axis_pinc_tdata(tdata), .m_axis_pinc_tvalid(tvalid), .m_axis_pinc_tready(tready),
      .m_axis_pinc_tlast(tlast), .m_axis_pinc_tuser(tuser),
      .busy(busy), .done(done), .cfg_err(cfg_err), .chirp_idx(chirp_idx)
   );

   always #5 sys_clock = ~sys_clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clock);
      #1;
   endtask

   task automatic set_cfg(input logic [31:0] fs, fst, input logic [15:0] ns, ng, nc);
      cfg_f_start = fs; cfg_f_step = fst; cfg_n_samp = ns; cfg_n_gap = ng; cfg_n_chirps = nc;
   endtask

   // Finite burst: every transferred beat is compared with f_start + k*f_step of its chirp
   task automatic run_burst(input logic [31:0] fs, fst, input logic [15:0] ns, ng, nc,
                            input int rdy_pct, input bit use_stall, input logic [31:0] stall_val);
      int beats = 0, dones = 0, gap = 0, cyc = 0, stalls = 0, k;
      bit in_gap = 0, pv = 0, pr = 0, pu = 0, pl = 0, rdy;
      logic [31:0] pd = '0, e;
      set_cfg(fs, fst, ns, ng, nc);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_tvalid", tvalid, 1);
      chk("start_busy", busy, 1);
      chk("start_tuser", tuser, 1);
      chk("start_tdata", tdata, fs);
      chk("start_idx", chirp_idx, 0);
      while (busy && cyc < 5000) begin
         cfg_f_start = $urandom; cfg_f_step = $urandom; cfg_n_samp = 16'($urandom);
         cfg_n_gap = 16'($urandom); cfg_n_chirps = 16'($urandom);
         if (pv && !pr) begin
            chk("hold_tvalid", tvalid, 1);
            chk("hold_tdata", tdata, pd);
            chk("hold_tuser", tuser, pu);
            chk("hold_tlast", tlast, pl);
         end
         if (in_gap) begin
            if (tvalid) begin
               chk("gap_len", gap, ng);
               in_gap = 0;
            end else gap++;
         end
         if (use_stall && tvalid && tdata == stall_val && stalls < 3) begin
            rdy = 0;
            stalls++;
         end else rdy = ($urandom_range(99) < rdy_pct);
         tready = rdy;
         pv = tvalid; pr = rdy; pd = tdata; pu = tuser; pl = tlast;
         if (tvalid && rdy) begin
            k = beats % int'(ns);
            e = fs + fst * 32'(k);
            chk("beat_tdata", tdata, e);
            chk("beat_tuser", tuser, k == 0);
            chk("beat_tlast", tlast, k == int'(ns) - 1);
            if (tlast) begin in_gap = 1; gap = 0; end
            beats++;
         end
         tick();
         if (done) dones++;
         cyc++;
      end
      chk("burst_timeout", busy, 0);
      chk("burst_beats", beats, int'(ns) * int'(nc));
      chk("burst_done_cnt", dones, 1);
      chk("burst_done_now", done, 1);
      chk("burst_idx", chirp_idx, nc);
      chk("burst_tvalid_off", tvalid, 0);
      tready = 1'b0;
      tick();
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_tuser", tuser, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_idx", chirp_idx, 0);
      sys_resetn = 1'b1;
      tick();

      run_burst(32'd1000, 32'd10, 16'd4, 16'd2, 16'd2, 100, 1'b0, '0);
      run_burst(32'd1000, 32'd10, 16'd4, 16'd2, 16'd2, 100, 1'b1, 32'd1010);
      run_burst(32'hFFFF_FFF0, 32'h10, 16'd3, 16'd0, 16'd1, 100, 1'b0, '0);
      run_burst(32'd77, 32'd3, 16'd1, 16'd1, 16'd3, 100, 1'b0, '0);
      for (int i = 0; i < 8; i++)
         run_burst($urandom, $urandom, 16'($urandom_range(6, 1)), 16'($urandom_range(3)),
                   16'($urandom_range(4, 1)), 60, 1'b0, '0);

      // continuous back-to-back chirps, then stop while the DDS stalls
      set_cfg(32'd5, 32'd1, 16'd2, 16'd0, 16'd0);
      tready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("cont_tvalid", tvalid, 1);
         chk("cont_tdata", tdata, (i % 2) ? 6 : 5);
         chk("cont_tuser", tuser, i % 2 == 0);
         chk("cont_tlast", tlast, i % 2 == 1);
         tick();
      end
      tready = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_pend_tvalid", tvalid, 1);
      chk("stop_pend_tdata", tdata, 5);
      chk("stop_pend_busy", busy, 1);
      tick();
      chk("stop_pend_hold", tdata, 5);
      tready = 1'b1;
      tick();
      chk("stop_tvalid", tvalid, 0);
      chk("stop_busy", busy, 0);
      chk("stop_done", done, 0);
      chk("stop_idx", chirp_idx, 5);
      tick();
      chk("stop_done_after", done, 0);

      // zero-length chirp rejected
      set_cfg(32'd1, 32'd1, 16'd0, 16'd0, 16'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("err_pulse", cfg_err, 1);
      chk("err_busy", busy, 0);
      chk("err_tvalid", tvalid, 0);
      tick();
      chk("err_one_cycle", cfg_err, 0);

      // start together with stop does nothing
      set_cfg(32'd1, 32'd1, 16'd2, 16'd0, 16'd1);
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      chk("ss_busy", busy, 0);
      chk("ss_tvalid", tvalid, 0);
      chk("ss_cfg_err", cfg_err, 0);

      // stop during the gap returns to idle at once
      set_cfg(32'd9, 32'd1, 16'd2, 16'd6, 16'd3);
      tready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("gapstop_in_gap", tvalid, 0);
      chk("gapstop_busy_pre", busy, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("gapstop_busy", busy, 0);
      chk("gapstop_done", done, 0);
      chk("gapstop_idx", chirp_idx, 1);

      // reset in the middle of a chirp
      set_cfg(32'd100, 32'd7, 16'd2, 16'd0, 16'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("mid_idx_pre", chirp_idx, 2);
      sys_resetn = 1'b0;
      tick();
      chk("mrst_tvalid", tvalid, 0);
      chk("mrst_tdata", tdata, 0);
      chk("mrst_tuser", tuser, 0);
      chk("mrst_tlast", tlast, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_idx", chirp_idx, 0);
      sys_resetn = 1'b1;
      tick();
      chk("mrst_stays_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
